serial_xor_add_ctrl: RTL and testbench
======================================

SERIAL_XOR_ADD_CTRL -- requirements
Module: serial_xor_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have parameter APPROX_BITS, default 2, number of approximate LSB positions (legal 0..WIDTH); used only when SERIAL_APPROX_LSB_EN is defined.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin an add with A, B.
REQ-006 SHALL have port A  input  WIDTH  operand A, sampled on acceptance.
REQ-007 SHALL have port B  input  WIDTH  operand B, sampled on acceptance.
REQ-008 SHALL have port ready  output  1  high when a new start can be accepted.
REQ-009 SHALL have port busy  output  1  high while bits are being processed.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port sum  output  WIDTH  result of the last completed operation.
REQ-012 SHALL have port cout  output  1  carry-out of the last completed operation.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; ready = (state==IDLE), busy = (state==RUN), done = (state==DONE).
REQ-014 SHALL accept a request on a rising edge where start=1 and state=IDLE: load A, B into shift registers, clear carry flop, clear bit counter, go to RUN.
REQ-015 SHALL, in RUN, process one bit per cycle LSB first: s = a0 ^ b0 ^ c (two cascaded 1-bit XOR stages), c_next = majority(a0, b0, c); shift operands right, shift s into the result register from the MSB side, increment counter.
REQ-016 SHALL go from RUN to DONE on the edge that processes bit WIDTH-1, i.e. the WIDTH-th edge after the acceptance edge; sum and cout update on that same edge.
REQ-017 SHALL hold done high for exactly one cycle, then return to IDLE on the next edge.
REQ-018 SHALL ignore start while in RUN or DONE; no queuing, operands not resampled.
REQ-019 SHALL hold sum and cout stable from DONE until the next completion; they SHALL NOT show partial results during RUN.
REQ-020 SHALL allow back-to-back operation: start asserted in the cycle after done is accepted, giving one idle cycle between operations.
REQ-021 SHALL implement unsigned arithmetic: {cout, sum} = A + B modulo 2^(WIDTH+1).
REQ-022 SHALL clear the counter on every acceptance; the counter SHALL NOT wrap within an operation.

Reset
REQ-023 SHALL, on rst_n low, immediately force state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, and clear the carry flop, counter and operand registers.
REQ-024 SHALL abort an operation in progress when reset is asserted mid-RUN; no done pulse SHALL follow and sum/cout stay 0.
REQ-025 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL use macro SERIAL_APPROX_LSB_EN to select approximate LSB mode.
REQ-027 SHALL, with SERIAL_APPROX_LSB_EN defined, compute bits 0..APPROX_BITS-1 as s = a0 ^ b0 with carry forced to 0 after each such bit; exact mode resumes at bit APPROX_BITS with carry-in 0.
REQ-028 SHALL, without SERIAL_APPROX_LSB_EN, compute all bits exactly and ignore APPROX_BITS; latency and handshake are identical in both builds.

Verification
REQ-029 SHALL check WIDTH=8, A=0x0F, B=0x01, start pulse -> done high 8 edges after acceptance for one cycle, sum=0x10, cout=0.
REQ-030 SHALL check A=0xFF, B=0x01 -> sum=0x00, cout=1; A=0x80, B=0x80 -> sum=0x00, cout=1.
REQ-031 SHALL check start held high through RUN with A/B changed mid-operation -> result uses originally sampled operands, second start accepted only after done, in IDLE.
REQ-032 SHALL check rst_n pulled low 3 cycles into RUN -> outputs 0 immediately, no done pulse, next operation A=0x05, B=0x03 -> sum=0x08.
REQ-033 SHALL check SERIAL_APPROX_LSB_EN defined, APPROX_BITS=2, A=0x03, B=0x01 -> sum=0x02, cout=0; A=0x07, B=0x05 -> sum=0x0A, cout=0.

Source files
------------

// File: rtl/serial_xor_add_ctrl_if.sv
// serial_xor_add_ctrl_if: start/operand/result bundle
// master = requester, slave = the serial adder
interface serial_xor_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, A, B,
      input  ready, busy, done, sum, cout
   );

   modport slave (
      input  start, A, B,
      output ready, busy, done, sum, cout
   );
endinterface

// File: rtl/serial_xor_add_ctrl.sv
// serial_xor_add_ctrl: bit-serial adder, one bit per clock, LSB first
// SERIAL_APPROX_LSB_EN: low APPROX_BITS bits are carry-less (XOR only)
module serial_xor_add_ctrl #(
   parameter int WIDTH       = 8,
   parameter int APPROX_BITS = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   serial_xor_add_ctrl_if.slave bus
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

`ifdef SERIAL_APPROX_LSB_EN
   localparam bit APX_EN = 1'b1;
`else
   localparam bit APX_EN = 1'b0;
`endif

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-2:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic             approx;
   logic             half_s;
   logic             bit_s;
   logic             bit_c;
   logic [WIDTH-1:0] shifted;

   // one-bit slice: two cascaded XORs plus majority carry
   always_comb begin
      approx  = APX_EN && (int'(cnt_q) < APPROX_BITS);
      half_s  = a_q[0] ^ b_q[0];
      bit_s   = approx ? half_s : (half_s ^ carry_q);
      bit_c   = approx ? 1'b0
              : ((a_q[0] & b_q[0]) | (a_q[0] & carry_q)
                 | (b_q[0] & carry_q));
      shifted = {bit_s, res_q};
   end

   // sequencing: accept, shift WIDTH bits, publish result, pulse done
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_d     = bus.A;
               b_d     = bus.B;
               carry_d = 1'b0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = bit_c;
            res_d   = shifted[WIDTH-1:1];
            if (cnt_q == LAST) begin
               sum_d   = shifted;
               cout_d  = bit_c;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign bus.ready = (state_q == S_IDLE);
   assign bus.busy  = (state_q == S_RUN);
   assign bus.done  = (state_q == S_DONE);
   assign bus.sum   = sum_q;
   assign bus.cout  = cout_q;

endmodule

// File: tb/tb_serial_xor_add_ctrl.sv
// tb_serial_xor_add_ctrl: random + directed operations vs arithmetic model
// define SERIAL_APPROX_LSB_EN for both DUT and bench to check approx build
module tb_serial_xor_add_ctrl;

   localparam int W  = 8;
   localparam int AB = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   serial_xor_add_ctrl_if #(.WIDTH(W)) bus ();

   serial_xor_add_ctrl #(
      .WIDTH      (W),
      .APPROX_BITS(AB)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] last_sum = '0;
   logic         last_cout = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // {cout, sum} from plain arithmetic
   function automatic logic [W:0] ref_add(input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      int unsigned r;
      int unsigned ua;
      int unsigned ub;
      ua = 32'(a);
      ub = 32'(b);
`ifdef SERIAL_APPROX_LSB_EN
      r = (((ua >> AB) + (ub >> AB)) << AB)
          | ((ua ^ ub) & ((32'd1 << AB) - 1));
`else
      r = ua + ub;
`endif
      return r[W:0];
   endfunction

   // called #1 after the acceptance edge; start already low
   task automatic finish_op(input string tag, input logic [W-1:0] a,
                            input logic [W-1:0] b);
      logic [W:0] e;
      int k;
      bit seen;
      e = ref_add(a, b);
      chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
      k = 0;
      seen = 1'b0;
      while (!seen && k < 20) begin
         chk({tag, ".hold"}, {23'd0, bus.cout, bus.sum},
             {23'd0, last_cout, last_sum});
         @(posedge clk);
         #1;
         k++;
         seen = bus.done;
      end
      chk({tag, ".latency"}, 32'(k), 32'(W));
      chk({tag, ".sum"}, 32'(bus.sum), 32'(e[W-1:0]));
      chk({tag, ".cout"}, 32'(bus.cout), 32'(e[W]));
      last_sum  = e[W-1:0];
      last_cout = e[W];
      @(posedge clk);
      #1;
      chk({tag, ".done_drop"}, 32'(bus.done), 32'd0);
      chk({tag, ".ready"}, 32'(bus.ready), 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b);
      chk({tag, ".idle"}, 32'(bus.ready), 32'd1);
      bus.start = 1'b1;
      bus.A = a;
      bus.B = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.A = W'($urandom);
      bus.B = W'($urandom);
      finish_op(tag, a, b);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] a0, b0, a1, b1;
      logic [W:0] e;
      int dn;

      bus.start = 1'b0;
      bus.A = '0;
      bus.B = '0;
      #1;
      chk("rst.ready", 32'(bus.ready), 32'd1);
      chk("rst.busy", 32'(bus.busy), 32'd0);
      chk("rst.done", 32'(bus.done), 32'd0);
      chk("rst.sum", 32'(bus.sum), 32'd0);
      chk("rst.cout", 32'(bus.cout), 32'd0);
      #11;
      rst_n = 1'b1;

      run_op("d0f01", 8'h0F, 8'h01);
      run_op("dff01", 8'hFF, 8'h01);
      run_op("d8080", 8'h80, 8'h80);
      run_op("d0301", 8'h03, 8'h01);
      run_op("d0705", 8'h07, 8'h05);
      run_op("d0000", 8'h00, 8'h00);
      run_op("dffff", 8'hFF, 8'hFF);

      // start held through RUN with operands changing
      a0 = 8'h5A;
      b0 = 8'hC3;
      bus.start = 1'b1;
      bus.A = a0;
      bus.B = b0;
      @(posedge clk);
      #1;
      a1 = '0;
      b1 = '0;
      for (int i = 0; i < W; i++) begin
         a1 = W'($urandom);
         b1 = W'($urandom);
         bus.A = a1;
         bus.B = b1;
         @(posedge clk);
         #1;
      end
      e = ref_add(a0, b0);
      chk("held.done", 32'(bus.done), 32'd1);
      chk("held.sum", 32'(bus.sum), 32'(e[W-1:0]));
      chk("held.cout", 32'(bus.cout), 32'(e[W]));
      last_sum  = e[W-1:0];
      last_cout = e[W];
      @(posedge clk);
      #1;
      chk("held.idle", 32'(bus.ready), 32'd1);
      chk("held.notbusy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      finish_op("held2", a1, b1);

      // abort three cycles into RUN
      bus.start = 1'b1;
      bus.A = 8'hAA;
      bus.B = 8'h77;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      chk("abort.ready", 32'(bus.ready), 32'd1);
      chk("abort.busy", 32'(bus.busy), 32'd0);
      chk("abort.done", 32'(bus.done), 32'd0);
      chk("abort.sum", 32'(bus.sum), 32'd0);
      chk("abort.cout", 32'(bus.cout), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      dn = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         dn += 32'(bus.done);
      end
      chk("abort.nodone", 32'(dn), 32'd0);
      chk("abort.sum0", 32'(bus.sum), 32'd0);
      last_sum  = '0;
      last_cout = 1'b0;
      run_op("abort.next", 8'h05, 8'h03);

      // start waiting during reset is taken on the first edge after release
      rst_n = 1'b0;
      bus.start = 1'b1;
      bus.A = 8'h21;
      bus.B = 8'h12;
      #3;
      rst_n = 1'b1;
      last_sum  = '0;
      last_cout = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      finish_op("post_rst", 8'h21, 8'h12);

      repeat (40) begin
         run_op("rand", W'($urandom), W'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
